// File: rtl/mult_operand_scheduler_pkg.sv
// Shared types and derived widths for the multiplier operand scheduler.
package mult_sched_pkg;

    // Scheduler FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_OUTPUT    = 3'd4
    } sched_state_e;

    // Default configuration and the widths derived from it.
    localparam int DEF_WORD_LENGTH = 4;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int PROD_W          = 2 * DEF_WORD_LENGTH;
    localparam int PTR_W           = $clog2(DEF_FIFO_DEPTH);

    // Product width for an arbitrary operand width (full width, no truncation).
    function automatic int prod_width(input int word_length);
        return 2 * word_length;
    endfunction

endpackage

// File: rtl/mult_operand_scheduler_fifo.sv
// Operand-pair FIFO: synchronous, show-ahead head, extra pointer bit for full/empty.
module op_pair_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    // Same index with differing wrap bits means every slot is occupied.
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // Storage array write; contents are don't-care until a pointer covers them.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Read and write pointers, wrapping modulo twice the depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/mult_operand_scheduler.sv
// Feeds buffered operand pairs to the multiplier one at a time and returns
// each product with its operands on a valid/ready stream, with stall timeout.
module mult_operand_scheduler
    import mult_sched_pkg::*;
#(
    parameter int WORD_LENGTH    = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORD_LENGTH-1:0]     in_word0,
    input  logic [WORD_LENGTH-1:0]     in_word1,
    output logic                       mul_start,
    output logic [WORD_LENGTH-1:0]     mul_word0,
    output logic [WORD_LENGTH-1:0]     mul_word1,
    input  logic                       mul_ready,
    input  logic [2*WORD_LENGTH-1:0]   mul_product,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*WORD_LENGTH-1:0]   out_product,
    output logic [WORD_LENGTH-1:0]     out_word0,
    output logic [WORD_LENGTH-1:0]     out_word1,
    output logic                       busy,
    output logic                       timeout_err
);
    localparam int PW    = prod_width(WORD_LENGTH);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    // The abort fires on the edge where the counter would reach TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    sched_state_e           r_state;
    sched_state_e           w_next;
    logic                   w_pop;
    logic                   w_capture;
    logic                   w_timeout;
    logic                   w_cnt_hit;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [PW-1:0]          w_head;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_mul_start;
    logic                   r_busy;
    logic                   r_out_valid;
    logic                   r_timeout_err;
    logic [WORD_LENGTH-1:0] r_mul_word0;
    logic [WORD_LENGTH-1:0] r_mul_word1;
    logic [PW-1:0]          r_out_product;
    logic [WORD_LENGTH-1:0] r_out_word0;
    logic [WORD_LENGTH-1:0] r_out_word1;

    op_pair_fifo #(
        .WIDTH (2 * WORD_LENGTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (in_valid),
        .i_pop   (w_pop),
        .i_data  ({in_word0, in_word1}),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_cnt_hit = (r_cnt == CNT_LAST);

    // Next-state logic plus the pop/capture/abort strobes it implies.
    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty && mul_ready) begin
                    w_next = ST_ISSUE;
                    w_pop  = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (w_cnt_hit) begin
                    w_next    = ST_IDLE;
                    w_timeout = 1'b1;
                end else if (!mul_ready) begin
                    w_next = ST_WAIT_DONE;
                end else begin
                    w_next = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                // A product arriving on the abort cycle still wins.
                if (mul_ready) begin
                    w_next    = ST_OUTPUT;
                    w_capture = 1'b1;
                end else if (w_cnt_hit) begin
                    w_next    = ST_IDLE;
                    w_timeout = 1'b1;
                end else begin
                    w_next = ST_WAIT_DONE;
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_OUTPUT;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Timeout counter: cleared while issuing, counts through both wait states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_cnt <= '0;
        end else if ((r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE)) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Operands to the multiplier, loaded on pop and held until the next pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mul_word0 <= '0;
            r_mul_word1 <= '0;
        end else if (w_pop) begin
            r_mul_word0 <= w_head[PW-1:WORD_LENGTH];
            r_mul_word1 <= w_head[WORD_LENGTH-1:0];
        end
    end

    // Result registers, captured when the multiplier reports done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_product <= '0;
            r_out_word0   <= '0;
            r_out_word1   <= '0;
        end else if (w_capture) begin
            r_out_product <= mul_product;
            r_out_word0   <= r_mul_word0;
            r_out_word1   <= r_mul_word1;
        end
    end

    // Registered status outputs decoded from the next state; error is sticky.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mul_start   <= 1'b0;
            r_busy        <= 1'b0;
            r_out_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_mul_start <= (w_next == ST_ISSUE);
            r_busy      <= (w_next != ST_IDLE);
            r_out_valid <= (w_next == ST_OUTPUT);
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign in_ready    = !w_fifo_full;
    assign mul_start   = r_mul_start;
    assign mul_word0   = r_mul_word0;
    assign mul_word1   = r_mul_word1;
    assign out_valid   = r_out_valid;
    assign out_product = r_out_product;
    assign out_word0   = r_out_word0;
    assign out_word1   = r_out_word1;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mult_operand_scheduler.sv
// Directed testbench for mult_operand_scheduler with a behavioural multiplier.
module tb_mult_operand_scheduler;

    localparam int WL = 4;
    localparam int DEPTH = 4;
    localparam int TO = 8;

    typedef struct {
        logic [7:0] p;
        logic [3:0] a;
        logic [3:0] b;
    } res_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
    } pair_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_word0 = 4'd0;
    logic [3:0] in_word1 = 4'd0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       mul_start;
    logic [3:0] mul_word0;
    logic [3:0] mul_word1;
    logic       out_valid;
    logic [7:0] out_product;
    logic [3:0] out_word0;
    logic [3:0] out_word1;
    logic       busy;
    logic       timeout_err;

    // behavioural multiplier
    logic       m_ready = 1'b1;
    logic [7:0] m_prod = 8'd0;
    logic [7:0] m_pend = 8'd0;
    int         m_cnt = 0;
    logic       stall = 1'b0;

    int   n_vec = 0;
    int   n_err = 0;
    int   start_cnt = 0;
    int   viol_cnt = 0;
    int   dbl_cnt = 0;
    logic prev_start = 1'b0;
    res_t  res_q[$];
    pair_t exp_q[$];

    mult_operand_scheduler #(
        .WORD_LENGTH    (WL),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_word0    (in_word0),
        .in_word1    (in_word1),
        .mul_start   (mul_start),
        .mul_word0   (mul_word0),
        .mul_word1   (mul_word1),
        .mul_ready   (m_ready),
        .mul_product (m_prod),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_word0   (out_word0),
        .out_word1   (out_word1),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Multiplier: start sampled while idle, busy 3 cycles, product garbage while busy.
    always @(posedge clk) begin
        if (m_ready && mul_start) begin
            m_pend  <= {4'd0, mul_word0} * {4'd0, mul_word1};
            m_prod  <= 8'hA5;
            m_ready <= 1'b0;
            m_cnt   <= 3;
        end else if (!m_ready && !stall) begin
            if (m_cnt == 1) begin
                m_ready <= 1'b1;
                m_prod  <= m_pend;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Collect accepted results and watch the start pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                res_q.push_back('{out_product, out_word0, out_word1});
            end
            if (mul_start) begin
                start_cnt <= start_cnt + 1;
                if (!m_ready) viol_cnt <= viol_cnt + 1;
                if (prev_start) dbl_cnt <= dbl_cnt + 1;
            end
        end
        prev_start <= mul_start;
    end

    // Offer one pair, waiting (bounded) for in_ready; called at posedge+1.
    task automatic push(input logic [3:0] a, input logic [3:0] b);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_word0 = a;
        in_word1 = b;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            k++;
            @(negedge clk);
        end
        n_vec++;
        if (!in_ready) begin
            n_err++;
            $display("FAIL push_wait: in_ready got %0b required 1", in_ready);
        end else begin
            exp_q.push_back('{a, b});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Bounded wait for a number of collected results.
    task automatic wait_res(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (res_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (res_q.size() < n) begin
            n_err++;
            $display("FAIL %s_wait: got %0d results required %0d", tag, res_q.size(), n);
        end
    endtask

    task automatic test_reset();
        #3;
        n_vec += 5;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        if (mul_start !== 1'b0) begin n_err++; $display("FAIL rst_mul_start: got %b required 0", mul_start); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
        if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %b required 0", timeout_err); end
        n_vec++;
        if (out_product !== 8'd0) begin n_err++; $display("FAIL rst_product: got %0d required 0", out_product); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int s0;
        int d0;
        res_q.delete();
        exp_q.delete();
        s0 = start_cnt;
        d0 = dbl_cnt;
        out_ready = 1'b1;
        push(4'd3, 4'd5);
        wait_res(1, 60, "single");
        if (res_q.size() >= 1) begin
            n_vec += 3;
            if (res_q[0].p !== 8'd15) begin n_err++; $display("FAIL single_product: got %0d required 15", res_q[0].p); end
            if (res_q[0].a !== 4'd3) begin n_err++; $display("FAIL single_word0: got %0d required 3", res_q[0].a); end
            if (res_q[0].b !== 4'd5) begin n_err++; $display("FAIL single_word1: got %0d required 5", res_q[0].b); end
        end
        repeat (3) @(negedge clk);
        n_vec += 3;
        if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy: got %b required 0", busy); end
        if (start_cnt - s0 != 1) begin n_err++; $display("FAIL single_starts: got %0d required 1", start_cnt - s0); end
        if (dbl_cnt != d0) begin n_err++; $display("FAIL single_pulse_width: got %0d long pulses required 0", dbl_cnt - d0); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] ep [3];
        logic [3:0] ea [3];
        logic [3:0] eb [3];
        ep = '{8'd225, 8'd0, 8'd1};
        ea = '{4'd15, 4'd0, 4'd1};
        eb = '{4'd15, 4'd9, 4'd1};
        res_q.delete();
        exp_q.delete();
        out_ready = 1'b1;
        push(4'd15, 4'd15);
        push(4'd0, 4'd9);
        push(4'd1, 4'd1);
        wait_res(3, 100, "b2b");
        for (int i = 0; i < 3; i++) begin
            if (i < res_q.size()) begin
                n_vec++;
                if (res_q[i].p !== ep[i] || res_q[i].a !== ea[i] || res_q[i].b !== eb[i])
                begin
                    n_err++;
                    $display("FAIL b2b_result%0d: got %0d (%0d,%0d) required %0d (%0d,%0d)",
                             i, res_q[i].p, res_q[i].a, res_q[i].b, ep[i], ea[i], eb[i]);
                end
            end
        end
        n_vec++;
        if (viol_cnt != 0) begin n_err++; $display("FAIL b2b_start_while_busy: got %0d required 0", viol_cnt); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int k;
        res_q.delete();
        exp_q.delete();
        out_ready = 1'b0;
        push(4'd2, 4'd3);
        push(4'd4, 4'd5);
        push(4'd6, 4'd7);
        push(4'd8, 4'd9);
        push(4'd10, 4'd11);
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full: in_ready got %b required 0", in_ready); end
        // sixth offer while full must be dropped
        in_valid = 1'b1;
        in_word0 = 4'd7;
        in_word1 = 4'd7;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_vec += 3;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_held: out_valid got %b required 1", out_valid); end
        if (res_q.size() != 0) begin n_err++; $display("FAIL bp_early: got %0d results required 0", res_q.size()); end
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_still_full: in_ready got %b required 0", in_ready); end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_res(5, 200, "bp");
        for (int i = 0; i < 5; i++) begin
            if (i < res_q.size()) begin
                n_vec++;
                if (res_q[i].a !== 4'(2 + 2 * i) || res_q[i].b !== 4'(3 + 2 * i) ||
                    res_q[i].p !== 8'((2 + 2 * i) * (3 + 2 * i))) begin
                    n_err++;
                    $display("FAIL bp_result%0d: got %0d (%0d,%0d) required %0d (%0d,%0d)",
                             i, res_q[i].p, res_q[i].a, res_q[i].b,
                             (2 + 2 * i) * (3 + 2 * i), 2 + 2 * i, 3 + 2 * i);
                end
            end
        end
        repeat (30) @(negedge clk);
        n_vec++;
        if (res_q.size() != 5) begin n_err++; $display("FAIL bp_count: got %0d results required 5", res_q.size()); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        int k;
        res_q.delete();
        exp_q.delete();
        out_ready = 1'b1;
        stall = 1'b1;
        push(4'd6, 4'd6);
        k = 0;
        while (!mul_start && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (mul_start !== 1'b1) begin n_err++; $display("FAIL to_issue: mul_start got %b required 1", mul_start); end
        repeat (7) @(negedge clk);
        n_vec++;
        if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_early: timeout_err got %b required 0", timeout_err); end
        @(negedge clk);
        n_vec += 2;
        if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_set: timeout_err got %b required 1", timeout_err); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL to_idle: busy got %b required 0", busy); end
        @(posedge clk);
        #1;
        // a second pair waits in the FIFO until the multiplier recovers
        push(4'd7, 4'd9);
        repeat (5) @(negedge clk);
        n_vec += 3;
        if (res_q.size() != 0) begin n_err++; $display("FAIL to_no_result: got %0d results required 0", res_q.size()); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL to_hold: busy got %b required 0", busy); end
        if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_sticky: timeout_err got %b required 1", timeout_err); end
        @(posedge clk);
        #1;
        stall = 1'b0;
        wait_res(1, 60, "to_recover");
        if (res_q.size() >= 1) begin
            n_vec++;
            if (res_q[0].p !== 8'd63 || res_q[0].a !== 4'd7 || res_q[0].b !== 4'd9) begin
                n_err++;
                $display("FAIL to_recover_result: got %0d (%0d,%0d) required 63 (7,9)",
                         res_q[0].p, res_q[0].a, res_q[0].b);
            end
        end
        n_vec++;
        if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_sticky2: timeout_err got %b required 1", timeout_err); end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop();
        res_q.delete();
        exp_q.delete();
        out_ready = 1'b1;
        push(4'd2, 4'd2);
        push(4'd3, 4'd3);
        push(4'd4, 4'd4);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        n_vec += 5;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b required 0", out_valid); end
        if (mul_start !== 1'b0) begin n_err++; $display("FAIL mid_mul_start: got %b required 0", mul_start); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b required 0", busy); end
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b required 1", in_ready); end
        if (timeout_err !== 1'b0) begin n_err++; $display("FAIL mid_timeout: got %b required 0", timeout_err); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (30) @(negedge clk);
        n_vec += 3;
        if (res_q.size() != 0) begin n_err++; $display("FAIL mid_ghost: got %0d results required 0", res_q.size()); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL mid_after_busy: got %b required 0", busy); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_after_valid: got %b required 0", out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit done;
        logic [7:0] e;
        done = 1'b0;
        res_q.delete();
        exp_q.delete();
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_res(exp_q.size(), 3000, "rand");
        repeat (20) @(negedge clk);
        n_vec++;
        if (res_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL rand_count: got %0d results required %0d", res_q.size(), exp_q.size());
        end
        for (int i = 0; i < res_q.size() && i < exp_q.size(); i++) begin
            e = {4'd0, exp_q[i].a} * {4'd0, exp_q[i].b};
            n_vec++;
            if (res_q[i].p !== e || res_q[i].a !== exp_q[i].a || res_q[i].b !== exp_q[i].b) begin
                n_err++;
                $display("FAIL rand_result%0d: got %0d (%0d,%0d) required %0d (%0d,%0d)",
                         i, res_q[i].p, res_q[i].a, res_q[i].b, e, exp_q[i].a, exp_q[i].b);
            end
        end
        n_vec++;
        if (viol_cnt != 0) begin n_err++; $display("FAIL rand_start_while_busy: got %0d required 0", viol_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
